// File: rtl/edge_toggle_gen_pkg.sv
// Shared definitions for the edge_toggle_gen slice: state encoding and sizing helpers.
package edge_toggle_gen_pkg;

    // State encodings. Two bits leave room for unused codes, which decode back to idle.
    localparam logic [1:0] IdleEnc = 2'b00;
    localparam logic [1:0] HoldEnc = 2'b01;

    typedef enum logic [1:0] {
        StIdle = IdleEnc,
        StHold = HoldEnc
    } etg_state_e;

    // Ceiling log2, constant-evaluable; clog2(0) and clog2(1) are both 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Hold counter width: at least one bit so MIN_HOLD=1 still has a real register.
    function automatic int unsigned cnt_width(input int unsigned min_hold);
        int unsigned w;
        w = clog2(min_hold);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_toggle_gen_hold_timer.sv
// Down-counter that times the minimum hold between level transitions.
// Loaded with MIN_HOLD-1 on every issue; expired_o is high once it has counted down to zero.
module edge_toggle_gen_hold_timer
    import edge_toggle_gen_pkg::*;
#(
    parameter int unsigned MIN_HOLD = 4,
    localparam int unsigned CntW = cnt_width(MIN_HOLD)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [CntW-1:0] load_value_i,
    output logic            expired_o
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/edge_toggle_gen.sv
// Event-to-level encoder: each accepted request pulse becomes one transition on level,
// with transitions spaced at least MIN_HOLD cycles apart. Requests arriving during a
// hold are queued in a saturating pending counter; a request that finds the queue full
// is dropped and flagged by a one-cycle overflow pulse.
module edge_toggle_gen
    import edge_toggle_gen_pkg::*;
#(
    parameter int unsigned MIN_HOLD = 4,
    parameter int unsigned PEND_W   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_in,
    output logic level,
    output logic busy,
    output logic overflow
);

    localparam int unsigned CntW = cnt_width(MIN_HOLD);
    localparam logic [CntW-1:0] HoldLoad = CntW'(MIN_HOLD - 1);
    localparam logic [PEND_W-1:0] PendMax = {PEND_W{1'b1}};

    etg_state_e        state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              level_q, level_d;
    logic              overflow_q, overflow_d;

    logic expired;
    logic issue_capable;
    logic pend_nz;
    logic issue;
    logic consume;
    logic direct;
    logic accept;
    logic drop;

    edge_toggle_gen_hold_timer #(
        .MIN_HOLD (MIN_HOLD)
    ) u_hold_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (issue),
        .load_value_i (HoldLoad),
        .expired_o    (expired)
    );

    // Issue decision, queue accounting and next-state for the FSM and output flops.
    always_comb begin
        issue_capable = 1'b0;
        state_d       = StIdle;
        case (state_q)
            StIdle: begin
                issue_capable = 1'b1;
                state_d       = StIdle;
            end
            StHold: begin
                issue_capable = expired;
                state_d       = expired ? StIdle : StHold;
            end
            default: begin
                issue_capable = 1'b0;
                state_d       = StIdle;
            end
        endcase

        pend_nz = (pending_q != '0);
        issue   = issue_capable & (pend_nz | tick_in);
        // The queue is served ahead of a same-cycle tick.
        consume = issue & pend_nz;
        direct  = issue & ~pend_nz & tick_in;
        accept  = tick_in & ~direct;
        drop    = accept & ~consume & (pending_q == PendMax);

        pending_d = pending_q;
        if (consume && !accept) begin
            pending_d = pending_q - PEND_W'(1);
        end else if (accept && !consume && !drop) begin
            pending_d = pending_q + PEND_W'(1);
        end

        if (issue) begin
            state_d = StHold;
        end

        level_d    = level_q ^ issue;
        overflow_d = drop;
    end

    // FSM state, pending counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            level_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign level    = level_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == StHold) | (pending_q != '0);

endmodule
